sync_selector: RTL and testbench

- Registered N-to-1 data selector.
- Picks one DATA-wide lane from a packed input vector, steered either by a binary index or by a priority bitmap.
- Reports which lane was chosen (one-hot) and whether any lane was selected.
- Used as a generic steering/priority-pick stage in datapaths. Outputs are registered on one clock.

---
 rtl/sync_selector_if.sv | 29 ++
 rtl/sync_selector.sv | 89 ++++++++
 tb/tb_sync_selector.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sync_selector_if.sv
// Lane/select bus for the registered N-to-1 selector.
// The master drives lanes and select; the slave returns the registered pick.
interface sync_selector_if #(
    parameter int DATA      = 32,
    parameter int IN        = 4,
    parameter int SEL_WIDTH = $clog2(IN)
);
    logic [DATA*IN-1:0]   in;
    logic [SEL_WIDTH-1:0] sel;
    logic                 valid;
    logic [IN-1:0]        pos;
    logic [DATA-1:0]      out;

    modport master (
        output in,
        output sel,
        input  valid,
        input  pos,
        input  out
    );

    modport slave (
        input  in,
        input  sel,
        output valid,
        output pos,
        output out
    );
endinterface

// File: rtl/sync_selector.sv
// Registered N-to-1 lane selector steered by a binary index or a
// priority request bitmap; reports the one-hot winner and a valid flag.
module sync_selector #(
    parameter int    DATA      = 32,
    parameter int    IN        = 4,
    parameter int    SEL_WIDTH = $clog2(IN),
    parameter string BIT_MAP   = "DISABLE",
    parameter string ACT       = "HIGH",
    parameter string MSB       = "ENABLE"
) (
    input logic           clk,
    input logic           reset,
    sync_selector_if.slave bus
);
    localparam bit ACT_HIGH  = (ACT == "HIGH");
    localparam bit MSB_FIRST = (MSB == "ENABLE");

    logic [IN-1:0]   pick_oh;
    logic [DATA-1:0] out_d;
    logic            valid_d;

    logic            valid_q;
    logic [IN-1:0]   pos_q;
    logic [DATA-1:0] out_q;

    if (BIT_MAP == "ENABLE") begin : g_bitmap
        logic [IN-1:0] req;

        // Select bits above IN carry no lane and are dropped here.
        assign req = ACT_HIGH ? bus.sel[IN-1:0]
                              : ~bus.sel[IN-1:0];

        always_comb begin
            pick_oh = '0;
            if (MSB_FIRST) begin
                for (int i = 0; i < IN; i++) begin
                    if (req[i]) begin
                        pick_oh    = '0;
                        pick_oh[i] = 1'b1;
                    end
                end
            end else begin
                for (int i = IN - 1; i >= 0; i--) begin
                    if (req[i]) begin
                        pick_oh    = '0;
                        pick_oh[i] = 1'b1;
                    end
                end
            end
        end
    end else begin : g_binary
        // Out-of-range indices match no lane and yield an empty pick.
        always_comb begin
            pick_oh = '0;
            for (int i = 0; i < IN; i++) begin
                if (bus.sel == SEL_WIDTH'(i)) begin
                    pick_oh[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_d = '0;
        for (int i = 0; i < IN; i++) begin
            if (pick_oh[i]) begin
                out_d = out_d | bus.in[DATA*i +: DATA];
            end
        end
    end

    assign valid_d = |pick_oh;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pos_q   <= '0;
            out_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pos_q   <= pick_oh;
            out_q   <= out_d;
        end
    end

    assign bus.valid = valid_q;
    assign bus.pos   = pos_q;
    assign bus.out   = out_q;
endmodule

// File: tb/tb_sync_selector.sv
// Bench for sync_selector: six configurations driven in parallel and
// checked each cycle against a list-based reference model.
module tb_sync_selector;
    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rs;
    logic [127:0] lanes4;
    logic [159:0] lanes5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // unit: 0 bin4, 1 bm hi/msb, 2 bm hi/lsb, 3 bm lo/msb, 4 bm sw8, 5 bin5
    int cfg_in [6] = '{4, 4, 4, 4, 4, 5};
    int cfg_sw [6] = '{2, 4, 4, 4, 8, 3};
    bit cfg_bm [6] = '{0, 1, 1, 1, 1, 0};
    bit cfg_hi [6] = '{1, 1, 1, 0, 1, 1};
    bit cfg_msb[6] = '{1, 1, 0, 1, 1, 1};

    sync_selector_if #(.DATA(32), .IN(4), .SEL_WIDTH(2)) if0 ();
    sync_selector_if #(.DATA(32), .IN(4), .SEL_WIDTH(4)) if1 ();
    sync_selector_if #(.DATA(32), .IN(4), .SEL_WIDTH(4)) if2 ();
    sync_selector_if #(.DATA(32), .IN(4), .SEL_WIDTH(4)) if3 ();
    sync_selector_if #(.DATA(32), .IN(4), .SEL_WIDTH(8)) if4 ();
    sync_selector_if #(.DATA(32), .IN(5), .SEL_WIDTH(3)) if5 ();

    assign if0.in = lanes4;  assign if0.sel = rs[1:0];
    assign if1.in = lanes4;  assign if1.sel = rs[3:0];
    assign if2.in = lanes4;  assign if2.sel = rs[3:0];
    assign if3.in = lanes4;  assign if3.sel = rs[3:0];
    assign if4.in = lanes4;  assign if4.sel = rs;
    assign if5.in = lanes5;  assign if5.sel = rs[2:0];

    sync_selector #(.DATA(32), .IN(4), .SEL_WIDTH(2), .BIT_MAP("DISABLE"),
        .ACT("HIGH"), .MSB("ENABLE")) u0 (.clk(clk), .reset(reset), .bus(if0));
    sync_selector #(.DATA(32), .IN(4), .SEL_WIDTH(4), .BIT_MAP("ENABLE"),
        .ACT("HIGH"), .MSB("ENABLE")) u1 (.clk(clk), .reset(reset), .bus(if1));
    sync_selector #(.DATA(32), .IN(4), .SEL_WIDTH(4), .BIT_MAP("ENABLE"),
        .ACT("HIGH"), .MSB("DISABLE")) u2 (.clk(clk), .reset(reset), .bus(if2));
    sync_selector #(.DATA(32), .IN(4), .SEL_WIDTH(4), .BIT_MAP("ENABLE"),
        .ACT("LOW"), .MSB("ENABLE")) u3 (.clk(clk), .reset(reset), .bus(if3));
    sync_selector #(.DATA(32), .IN(4), .SEL_WIDTH(8), .BIT_MAP("ENABLE"),
        .ACT("HIGH"), .MSB("ENABLE")) u4 (.clk(clk), .reset(reset), .bus(if4));
    sync_selector #(.DATA(32), .IN(5), .SEL_WIDTH(3), .BIT_MAP("DISABLE"),
        .ACT("HIGH"), .MSB("ENABLE")) u5 (.clk(clk), .reset(reset), .bus(if5));

    logic        dut_v[6];
    logic [7:0]  dut_p[6];
    logic [31:0] dut_o[6];

    assign dut_v[0] = if0.valid; assign dut_p[0] = 8'(if0.pos); assign dut_o[0] = if0.out;
    assign dut_v[1] = if1.valid; assign dut_p[1] = 8'(if1.pos); assign dut_o[1] = if1.out;
    assign dut_v[2] = if2.valid; assign dut_p[2] = 8'(if2.pos); assign dut_o[2] = if2.out;
    assign dut_v[3] = if3.valid; assign dut_p[3] = 8'(if3.pos); assign dut_o[3] = if3.out;
    assign dut_v[4] = if4.valid; assign dut_p[4] = 8'(if4.pos); assign dut_o[4] = if4.out;
    assign dut_v[5] = if5.valid; assign dut_p[5] = 8'(if5.pos); assign dut_o[5] = if5.out;

    logic        exp_v[6];
    logic [7:0]  exp_p[6];
    logic [31:0] exp_o[6];

    function automatic logic [31:0] lane(input int u, input int w);
        if (u == 5) return lanes5[32*w +: 32];
        return lanes4[32*w +: 32];
    endfunction

    // Winner from the rules: index value in binary mode, else the
    // list of requesting lanes and its first or last entry.
    function automatic void model(input int u, input logic [7:0] s,
                                  input logic rst, output logic v,
                                  output logic [7:0] p, output logic [31:0] o);
        int n;
        int win;
        int idx;
        int reqs[$];
        n   = cfg_in[u];
        win = -1;
        if (!rst) begin
            if (!cfg_bm[u]) begin
                idx = int'(s) % (1 << cfg_sw[u]);
                if (idx < n) win = idx;
            end else begin
                for (int i = 0; i < n; i++)
                    if (s[i] == cfg_hi[u]) reqs.push_back(i);
                if (reqs.size() > 0)
                    win = cfg_msb[u] ? reqs[reqs.size()-1] : reqs[0];
            end
        end
        v = (win >= 0);
        p = v ? 8'(1 << win) : 8'h0;
        o = v ? lane(u, win) : 32'h0;
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 6; u++) begin
            logic        v;
            logic [7:0]  p;
            logic [31:0] o;
            model(u, rs, reset, v, p, o);
            exp_v[u] <= v;
            exp_p[u] <= p;
            exp_o[u] <= o;
        end
    end

    task automatic compare_all();
        for (int u = 0; u < 6; u++) begin
            checks++;
            if (dut_v[u] !== exp_v[u] || dut_p[u] !== exp_p[u] ||
                dut_o[u] !== exp_o[u]) begin
                errors++;
                $display("FAIL model_u%0d got v=%b p=%h o=%h want v=%b p=%h o=%h",
                         u, dut_v[u], dut_p[u], dut_o[u],
                         exp_v[u], exp_p[u], exp_o[u]);
            end
        end
    endtask

    task automatic cycle(input logic [7:0] v, input logic r, input bit rnd);
        @(posedge clk);
        #2;
        rs    = v;
        reset = r;
        if (rnd) begin
            lanes4 = {$urandom, $urandom, $urandom, $urandom};
            lanes5 = {$urandom, $urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input logic [7:0] v);
        cycle(v, 1'b0, 1'b0);
        cycle(v, 1'b0, 1'b0);
    endtask

    task automatic lit(input string nm, input int u, input logic v,
                       input logic [7:0] p, input logic [31:0] o);
        checks++;
        if (dut_v[u] !== v || dut_p[u] !== p || dut_o[u] !== o) begin
            errors++;
            $display("FAIL %s got v=%b p=%h o=%h want v=%b p=%h o=%h",
                     nm, dut_v[u], dut_p[u], dut_o[u], v, p, o);
        end
    endtask

    initial begin
        reset  = 1'b1;
        rs     = 8'h0;
        lanes4 = {32'd4, 32'd3, 32'd2, 32'd1};
        lanes5 = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};

        cycle(8'h2, 1'b1, 1'b0);
        cycle(8'h2, 1'b1, 1'b0);
        lit("reset_u0", 0, 1'b0, 8'h0, 32'h0);
        lit("reset_u1", 1, 1'b0, 8'h0, 32'h0);

        hold(8'h0); lit("bin_sel0", 0, 1'b1, 8'h1, 32'd1);
        hold(8'h1); lit("bin_sel1", 0, 1'b1, 8'h2, 32'd2);
        hold(8'h2); lit("bin_sel2", 0, 1'b1, 8'h4, 32'd3);
        hold(8'h3); lit("bin_sel3", 0, 1'b1, 8'h8, 32'd4);

        cycle(8'h2, 1'b1, 1'b0);
        cycle(8'h2, 1'b0, 1'b0);
        lit("reset_mid", 0, 1'b0, 8'h0, 32'h0);
        cycle(8'h2, 1'b0, 1'b0);
        lit("after_reset", 0, 1'b1, 8'h4, 32'd3);

        hold(8'b0001); lit("msb_0001", 1, 1'b1, 8'h1, 32'd1);
        hold(8'b0011); lit("msb_0011", 1, 1'b1, 8'h2, 32'd2);
        hold(8'b0101); lit("msb_0101", 1, 1'b1, 8'h4, 32'd3);
        hold(8'b1001); lit("msb_1001", 1, 1'b1, 8'h8, 32'd4);
        hold(8'b1111); lit("msb_1111", 1, 1'b1, 8'h8, 32'd4);
        hold(8'b0000); lit("msb_none", 1, 1'b0, 8'h0, 32'h0);

        hold(8'b0110); lit("lsb_0110", 2, 1'b1, 8'h2, 32'd2);
        hold(8'b1100); lit("lsb_1100", 2, 1'b1, 8'h4, 32'd3);
        hold(8'b1111); lit("lsb_1111", 2, 1'b1, 8'h1, 32'd1);

        hold(8'b1110); lit("low_1110", 3, 1'b1, 8'h1, 32'd1);
        hold(8'b1111); lit("low_1111", 3, 1'b0, 8'h0, 32'h0);
        hold(8'b0000); lit("low_0000", 3, 1'b1, 8'h8, 32'd4);

        hold(8'h60); lit("wide_hi_only", 4, 1'b0, 8'h0, 32'h0);
        hold(8'h65); lit("wide_mixed", 4, 1'b1, 8'h4, 32'd3);

        hold(8'h5); lit("bin5_idx5", 5, 1'b0, 8'h0, 32'h0);
        hold(8'h4); lit("bin5_idx4", 5, 1'b1, 8'h10, 32'd5);
        hold(8'h7); lit("bin5_idx7", 5, 1'b0, 8'h0, 32'h0);

        for (int k = 0; k < 400; k++) begin
            cycle(8'($urandom), ($urandom_range(0, 19) == 0), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
